aer_row_arbiter_16: RTL and testbench

AER_ROW_ARBITER_16 -- requirements
Module: aer_row_arbiter_16

---
 rtl/aer_row_arbiter_16.sv | 129 ++++++++++++
 tb/tb_aer_row_arbiter_16.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/aer_row_arbiter_16.sv
// AER row arbiter: 16 level requests -> one-hot grant/row ack plus a four-phase off-chip handshake.
// Define ROUND_ROBIN_EN for a rotating-priority winner; the default build uses fixed lowest-index priority.
module aer_row_arbiter_16 #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic [3:0]  addr,
  output logic        out_req,
  input  logic        out_ack,
  output logic        err_timeout,
  output logic [15:0] evt_cnt
);

  // state | meaning
  // IDLE  | no grant; waiting for any req
  // REQ   | row granted, out_req high, waiting for out_ack or timeout
  // REL   | out_req low, waiting for out_ack=0 and granted req to drop
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t      state, state_n;
  logic [15:0] grant_n, evt_n;
  logic [3:0]  addr_n, win;
  logic        out_req_n, err_n;
  logic [7:0]  wcnt, wcnt_n;
`ifdef ROUND_ROBIN_EN
  logic [3:0]  ptr, ptr_n, idx;
`endif

  // Descending loop: the last hit is the highest-priority candidate.
  always_comb begin
    win = 4'd0;
`ifdef ROUND_ROBIN_EN
    idx = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      idx = ptr + 4'(k);
      if (req[idx]) win = idx;
    end
`else
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) win = 4'(i);
    end
`endif
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    addr_n    = addr;
    out_req_n = out_req;
    err_n     = 1'b0;
    evt_n     = evt_cnt;
    wcnt_n    = wcnt;
`ifdef ROUND_ROBIN_EN
    ptr_n     = ptr;
`endif
    case (state)
      IDLE: begin
        grant_n   = 16'd0;
        out_req_n = 1'b0;
        if (|req) begin
          grant_n   = 16'd1 << win;
          addr_n    = win;
          out_req_n = 1'b1;
          wcnt_n    = 8'd0;
          state_n   = REQ;
`ifdef ROUND_ROBIN_EN
          ptr_n     = win + 4'd1;
`endif
        end
      end
      REQ: begin
        if (out_ack) begin
          out_req_n = 1'b0;
          evt_n     = evt_cnt + 16'd1;
          state_n   = REL;
        end else if (TIMEOUT != 8'd0) begin
          // Counter saturates at TIMEOUT; reaching it drops the event.
          if (wcnt != TIMEOUT) wcnt_n = wcnt + 8'd1;
          if (wcnt == TIMEOUT - 8'd1 || wcnt == TIMEOUT) begin
            out_req_n = 1'b0;
            err_n     = 1'b1;
            state_n   = REL;
          end
        end
      end
      REL: begin
        if (!out_ack && !req[addr]) begin
          grant_n = 16'd0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n   = IDLE;
        grant_n   = 16'd0;
        out_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 16'd0;
      addr        <= 4'd0;
      out_req     <= 1'b0;
      err_timeout <= 1'b0;
      evt_cnt     <= 16'd0;
      wcnt        <= 8'd0;
`ifdef ROUND_ROBIN_EN
      ptr         <= 4'd0;
`endif
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      addr        <= addr_n;
      out_req     <= out_req_n;
      err_timeout <= err_n;
      evt_cnt     <= evt_n;
      wcnt        <= wcnt_n;
`ifdef ROUND_ROBIN_EN
      ptr         <= ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_aer_row_arbiter_16.sv
// Directed self-checking bench for aer_row_arbiter_16 (TIMEOUT=4), plus random-traffic grant properties.
module tb_aer_row_arbiter_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        out_ack;
  logic [15:0] grant;
  logic [3:0]  addr;
  logic        out_req;
  logic        err_timeout;
  logic [15:0] evt_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  aer_row_arbiter_16 #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .addr(addr),
    .out_req(out_req), .out_ack(out_ack), .err_timeout(err_timeout), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full handshake where the winner drops its request on grant and reasserts afterwards.
  task automatic handshake(input logic [3:0] exp_addr, input logic [15:0] req_all);
    tick;
    chk("cont_addr", addr, exp_addr);
    chk("cont_grant", grant, 32'd1 << exp_addr);
    req     = req_all & ~(16'd1 << exp_addr);
    out_ack = 1'b1;
    tick;
    chk("cont_req_low", out_req, 0);
    out_ack = 1'b0;
    tick;
    chk("cont_release", grant, 0);
    req = req_all;
  endtask

  logic [3:0] exp_ord [4];
  int         gidx;

  initial begin
`ifdef ROUND_ROBIN_EN
    exp_ord = '{4'd0, 4'd15, 4'd0, 4'd15};
`else
    exp_ord = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif
    rst = 1'b1; req = 16'd0; out_ack = 1'b0;
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_addr", addr, 0);
    chk("rst_out_req", out_req, 0);
    chk("rst_evt", evt_cnt, 0);
    chk("rst_err", err_timeout, 0);
    tick;
    rst = 1'b0;
    req = 16'h0010;

    // Single event, granted on the first edge after reset release
    tick;
    chk("single_grant", grant, 16'h0010);
    chk("single_addr", addr, 4);
    chk("single_out_req", out_req, 1);
    tick;
    tick;
    chk("single_wait", out_req, 1);
    out_ack = 1'b1;
    tick;
    chk("single_req_fall", out_req, 0);
    chk("single_evt", evt_cnt, 1);
    chk("single_grant_held", grant, 16'h0010);
    out_ack = 1'b0;
    req     = 16'd0;
    tick;
    chk("single_grant_clr", grant, 0);
    tick;
    chk("single_addr_hold", addr, 4);

    // Contention from a clean pointer
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    req = 16'h8001;
    for (int i = 0; i < 4; i++) handshake(exp_ord[i], 16'h8001);
    chk("cont_evt", evt_cnt, 4);
    req = 16'd0;
    tick;

    // Timeout: out_ack never returns
    req = 16'h0004;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("to_out_req_high", out_req, 1);
      chk("to_no_err", err_timeout, 0);
    end
    chk("to_addr", addr, 2);
    tick;
    chk("to_out_req_low", out_req, 0);
    chk("to_err_pulse", err_timeout, 1);
    chk("to_evt_same", evt_cnt, 4);
    tick;
    chk("to_err_once", err_timeout, 0);
    chk("to_grant_held", grant, 16'h0004);
    req = 16'd0;
    tick;
    chk("to_idle", grant, 0);

    // Stuck ack in REL
    req = 16'h0100;
    tick;
    chk("stuck_grant", grant, 16'h0100);
    out_ack = 1'b1;
    tick;
    chk("stuck_evt", evt_cnt, 5);
    req = 16'd0;
    tick;
    tick;
    chk("stuck_held", grant, 16'h0100);
    out_ack = 1'b0;
    tick;
    chk("stuck_release", grant, 0);

    // Asynchronous reset in the middle of REQ
    req = 16'h0001;
    tick;
    chk("mid_out_req", out_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_out_req", out_req, 0);
    chk("mid_rst_evt", evt_cnt, 0);
    #2 rst = 1'b0;
    req = 16'd0;
    tick;

    // Random traffic: grant one-hot or zero, addr tracks grant
    for (int n = 0; n < 300; n++) begin
      req     = 16'($urandom);
      out_ack = ($urandom_range(0, 3) == 0);
      tick;
      chk("prop_onehot", $onehot0(grant), 1);
      if (grant != 16'd0) begin
        gidx = 0;
        for (int b = 0; b < 16; b++) if (grant[b]) gidx = b;
        chk("prop_addr", addr, gidx);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
